// File: rtl/staff_note_playback.sv
// -----------------------------------------------------------------------------
// staff_note_playback
//
// Steps through a score stored in an external memory, one staff cell per
// sixteenth-note tick. Each staff cell holds five voice slots of 12 bits,
// laid out as {rhythm[3:0], note[7:0]}. A note of 8'hFF marks an empty slot.
// An empty slot sustains: the voice keeps its current note and duration.
// Each voice counts down its remaining duration, and the voice sounds while
// that count is nonzero.
//
// Per-cell sequence: FETCH (one-cycle read strobe) -> WAIT1 -> WAIT2. The
// memory data is captured on the edge that leaves WAIT2. PLAY then waits
// for a tick. A tick in PLAY decrements the counters and moves to the next
// cell, wraps to cell 0, or finishes.
//
// Ports
//   clk_in                  system clock
//   rst_in                  asynchronous active-high reset
//   start_in                pulse: (re)start playback at cell 0
//   stop_in                 pulse: abort playback (wins over start_in)
//   sixteenth_tick_in       pulse: one per sixteenth note
//   num_cells_in[5:0]       cells to play, sampled on start; 0 = none
//   loop_in                 wrap to cell 0 after the last cell (sampled live)
//   mem_rd_out              score-memory read strobe
//   mem_addr_out[5:0]       staff cell address for the read
//   mem_data_in[59:0]       five slots; valid two cycles after mem_rd_out
//   notes_out[39:0]         note per voice, voice i = bits [8i+7:8i]
//   note_rhythms_out[19:0]  rhythm per voice, voice i = bits [4i+3:4i]
//   note_on_out[4:0]        voice sounding (remaining duration nonzero)
//   current_staff_cell_out  cell being played
//   cell_valid_out          one-cycle pulse when new cell data is presented
//   busy_out                playback active (any state but IDLE)
//   done_out                one-cycle pulse at the end of non-looping playback
//   overrun_out             sticky: a tick was lost
// -----------------------------------------------------------------------------
module staff_note_playback (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic        sixteenth_tick_in,
    input  logic [5:0]  num_cells_in,
    input  logic        loop_in,
    output logic        mem_rd_out,
    output logic [5:0]  mem_addr_out,
    input  logic [59:0] mem_data_in,
    output logic [39:0] notes_out,
    output logic [19:0] note_rhythms_out,
    output logic [4:0]  note_on_out,
    output logic [5:0]  current_staff_cell_out,
    output logic        cell_valid_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        overrun_out
);

    localparam int NV = 5;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT1, WAIT2, PLAY} state_t;

    state_t             r_state;
    logic [5:0]         r_num_cells;
    logic               r_pending;
    logic [NV-1:0][4:0] r_counter;

    // Control decode. stop_in overrides everything, and start_in overrides
    // normal sequencing, so both gate the PLAY tick and the WAIT2 load.
    logic       w_start;
    logic       w_start_empty;
    logic       w_tick_play;
    logic       w_more;
    logic       w_finish;
    logic       w_clear;
    logic       w_load_phase;
    logic [5:0] w_next_cell;

    assign w_start       = start_in && !stop_in;
    assign w_start_empty = w_start && (num_cells_in == 6'd0);
    // A tick that arrived during the fetch is held in r_pending.
    // That held tick counts as a tick in the first PLAY cycle.
    assign w_tick_play   = (r_state == PLAY) && !stop_in && !start_in &&
                           (sixteenth_tick_in || r_pending);
    // Widen to 7 bits so cell+1 can never wrap before the compare.
    assign w_more        = ({1'b0, current_staff_cell_out} + 7'd1) < {1'b0, r_num_cells};
    assign w_finish      = w_tick_play && !w_more && !loop_in;
    assign w_clear       = stop_in || w_start_empty || w_finish;
    assign w_load_phase  = (r_state == WAIT2) && !stop_in && !start_in;
    assign w_next_cell   = w_more ? (current_staff_cell_out + 6'd1) : 6'd0;

    // Per-voice next-state logic.
    logic [NV-1:0][4:0] w_counter_next;
    logic [NV-1:0]      w_note_on_next;
    logic [39:0]        w_notes_next;
    logic [19:0]        w_rhythms_next;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_voice
            logic [7:0] w_slot_note;
            logic [3:0] w_slot_rhythm;
            logic       w_load;
            logic [4:0] w_load_value;
            logic [4:0] w_dec_value;

            assign w_slot_note   = mem_data_in[12*gi +: 8];
            assign w_slot_rhythm = mem_data_in[12*gi+8 +: 4];
            assign w_load        = w_load_phase && (w_slot_note != 8'hFF);
            // Rhythm 0 encodes a whole note: 16 sixteenths.
            assign w_load_value  = (w_slot_rhythm == 4'd0) ? 5'd16 : {1'b0, w_slot_rhythm};
            assign w_dec_value   = (r_counter[gi] != 5'd0) ? (r_counter[gi] - 5'd1) : 5'd0;

            // Priority: clear, then load, then decrement. A load beats a
            // decrement in the same cycle.
            assign w_counter_next[gi] = w_clear     ? 5'd0 :
                                        w_load      ? w_load_value :
                                        w_tick_play ? w_dec_value :
                                                      r_counter[gi];
            assign w_note_on_next[gi] = (w_counter_next[gi] != 5'd0);

            assign w_notes_next[8*gi +: 8]   = w_load ? w_slot_note   : notes_out[8*gi +: 8];
            assign w_rhythms_next[4*gi +: 4] = w_load ? w_slot_rhythm : note_rhythms_out[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state                <= IDLE;
            r_num_cells            <= 6'd0;
            r_pending              <= 1'b0;
            r_counter              <= '0;
            notes_out              <= {NV{8'hFF}};
            note_rhythms_out       <= 20'd0;
            note_on_out            <= 5'd0;
            mem_rd_out             <= 1'b0;
            mem_addr_out           <= 6'd0;
            current_staff_cell_out <= 6'd0;
            cell_valid_out         <= 1'b0;
            busy_out               <= 1'b0;
            done_out               <= 1'b0;
            overrun_out            <= 1'b0;
        end else begin
            // Pulse outputs default low.
            mem_rd_out       <= 1'b0;
            cell_valid_out   <= 1'b0;
            done_out         <= 1'b0;

            r_counter        <= w_counter_next;
            note_on_out      <= w_note_on_next;
            notes_out        <= w_notes_next;
            note_rhythms_out <= w_rhythms_next;

            if (stop_in) begin
                r_state   <= IDLE;
                busy_out  <= 1'b0;
                r_pending <= 1'b0;
            end else if (start_in) begin
                r_pending <= 1'b0;
                if (num_cells_in != 6'd0) begin
                    r_num_cells            <= num_cells_in;
                    current_staff_cell_out <= 6'd0;
                    mem_addr_out           <= 6'd0;
                    mem_rd_out             <= 1'b1;
                    busy_out               <= 1'b1;
                    r_state                <= FETCH;
                end else begin
                    // Nothing to play: finish straight away.
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    r_state  <= IDLE;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        busy_out <= 1'b0;
                    end
                    FETCH, WAIT1, WAIT2: begin
                        // Only one tick can be held. A second tick is lost.
                        if (sixteenth_tick_in) begin
                            if (r_pending) overrun_out <= 1'b1;
                            else           r_pending   <= 1'b1;
                        end
                        if (r_state == FETCH)      r_state <= WAIT1;
                        else if (r_state == WAIT1) r_state <= WAIT2;
                        else begin
                            r_state        <= PLAY;
                            cell_valid_out <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (w_tick_play) begin
                            // The held tick and a live tick arrived together.
                            // Only one can be used, so the other is lost.
                            if (r_pending && sixteenth_tick_in) overrun_out <= 1'b1;
                            r_pending <= 1'b0;
                            if (w_more || loop_in) begin
                                current_staff_cell_out <= w_next_cell;
                                mem_addr_out           <= w_next_cell;
                                mem_rd_out             <= 1'b1;
                                r_state                <= FETCH;
                            end else begin
                                busy_out <= 1'b0;
                                done_out <= 1'b1;
                                r_state  <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_staff_note_playback.sv
// Testbench for staff_note_playback.
// Stimulus tasks push the expected events into a scoreboard queue:
// read strobes, cell_valid presentations and done pulses.
// A monitor process pops from that queue and compares whenever the DUT
// raises one of those outputs.
module tb_staff_note_playback;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        sixteenth_tick_in = 1'b0;
    logic [5:0]  num_cells_in = 6'd0;
    logic        loop_in = 1'b0;
    logic        mem_rd_out;
    logic [5:0]  mem_addr_out;
    logic [59:0] mem_data_in;
    logic [39:0] notes_out;
    logic [19:0] note_rhythms_out;
    logic [4:0]  note_on_out;
    logic [5:0]  current_staff_cell_out;
    logic        cell_valid_out;
    logic        busy_out;
    logic        done_out;
    logic        overrun_out;

    staff_note_playback dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .start_in               (start_in),
        .stop_in                (stop_in),
        .sixteenth_tick_in      (sixteenth_tick_in),
        .num_cells_in           (num_cells_in),
        .loop_in                (loop_in),
        .mem_rd_out             (mem_rd_out),
        .mem_addr_out           (mem_addr_out),
        .mem_data_in            (mem_data_in),
        .notes_out              (notes_out),
        .note_rhythms_out       (note_rhythms_out),
        .note_on_out            (note_on_out),
        .current_staff_cell_out (current_staff_cell_out),
        .cell_valid_out         (cell_valid_out),
        .busy_out               (busy_out),
        .done_out               (done_out),
        .overrun_out            (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Number of rising edges so far. The period after edge k has cyc == k.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Score memory model with two-cycle read latency. Outside the valid
    // window it returns junk, so a mistimed capture shows up.
    localparam logic [59:0] JUNK  = {5{12'h5AB}};
    localparam logic [11:0] EMPTY = 12'h0FF;
    logic [59:0] score [64];
    logic [59:0] d1 = JUNK;
    logic [59:0] d2 = JUNK;
    always @(posedge clk_in) begin
        d1 <= mem_rd_out ? score[mem_addr_out] : JUNK;
        d2 <= d1;
    end
    assign mem_data_in = d2;

    // Scoreboard event kinds: 0 = read strobe, 1 = cell_valid, 2 = done.
    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [39:0] notes;
        logic [19:0] rhy;
        logic [4:0]  on;
        int          at;
    } ev_t;
    ev_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push_ev(input int kind, input logic [5:0] a, input logic [39:0] nt,
                           input logic [19:0] rh, input logic [4:0] on, input int at);
        ev_t e;
        e.kind = kind; e.addr = a; e.notes = nt; e.rhy = rh; e.on = on; e.at = at;
        sb.push_back(e);
    endtask

    // mode 0: nothing expected, 1: read only, 2: read + cell_valid, 3: done
    task automatic expect_step(input int mode, input int at, input logic [5:0] a,
                               input logic [39:0] nt, input logic [19:0] rh, input logic [4:0] on);
        if (mode == 1 || mode == 2) push_ev(0, a, '0, '0, '0, at);
        if (mode == 2)              push_ev(1, a, nt, rh, on, at + 3);
        if (mode == 3)              push_ev(2, '0, '0, '0, '0, at);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                $display("event kind=%0d cycle=%0d addr=%0d notes=%h on=%b", kind, cyc,
                         current_staff_cell_out, notes_out, note_on_out);
                check("event_cycle", cyc, e.at);
                if (kind == 0) begin
                    check("rd_addr", mem_addr_out, e.addr);
                    check("rd_cell", current_staff_cell_out, e.addr);
                end else if (kind == 1) begin
                    check("cv_cell", current_staff_cell_out, e.addr);
                    check("cv_notes", notes_out, e.notes);
                    check("cv_rhythms", note_rhythms_out, e.rhy);
                    check("cv_note_on", note_on_out, e.on);
                    check("cv_busy", busy_out, 1'b1);
                end else begin
                    check("done_busy", busy_out, 1'b0);
                end
            end
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (mem_rd_out)     handle(0);
            if (cell_valid_out) handle(1);
            if (done_out)       handle(2);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic go(input logic [5:0] n, input int mode, input logic [5:0] a,
                      input logic [39:0] nt, input logic [19:0] rh, input logic [4:0] on);
        @(negedge clk_in);
        num_cells_in = n;
        start_in = 1'b1;
        expect_step(mode, cyc + 1, a, nt, rh, on);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic tick(input int mode, input logic [5:0] a, input logic [39:0] nt,
                        input logic [19:0] rh, input logic [4:0] on);
        @(negedge clk_in);
        sixteenth_tick_in = 1'b1;
        expect_step(mode, cyc + 1, a, nt, rh, on);
        @(negedge clk_in);
        sixteenth_tick_in = 1'b0;
    endtask

    task automatic stop_pulse();
        @(negedge clk_in);
        stop_in = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        $display("reset check %s", tag);
        check({tag, "_notes"},   notes_out, 40'hFFFF_FFFF_FF);
        check({tag, "_rhythms"}, note_rhythms_out, 20'd0);
        check({tag, "_note_on"}, note_on_out, 5'd0);
        check({tag, "_mem_rd"},  mem_rd_out, 1'b0);
        check({tag, "_addr"},    mem_addr_out, 6'd0);
        check({tag, "_cell"},    current_staff_cell_out, 6'd0);
        check({tag, "_cv"},      cell_valid_out, 1'b0);
        check({tag, "_busy"},    busy_out, 1'b0);
        check({tag, "_done"},    done_out, 1'b0);
        check({tag, "_overrun"}, overrun_out, 1'b0);
    endtask

    // Assert reset mid-cycle and check the outputs straight away.
    // Reset is asynchronous, so they must already be at reset values.
    task automatic do_reset(input string tag);
        check({tag, "_sb_drained"}, sb.size(), 0);
        sb.delete();
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1 check_reset_values(tag);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    localparam logic [39:0] NT_3C = 40'hFFFF_FFFF_3C;
    localparam logic [39:0] NT_S0 = 40'hFFFF_4140_3C;
    localparam logic [39:0] NT_S2 = 40'hFF50_4140_3C;

    initial begin
        for (int i = 0; i < 64; i++) score[i] = {5{EMPTY}};
        do_reset("reset0");

        // 1: two cells, no loop. Rhythm 2 on voice 0; cell 1 sustains.
        score[0] = {EMPTY, EMPTY, EMPTY, EMPTY, {4'd2, 8'h3C}};
        go(6'd2, 2, 6'd0, NT_3C, 20'h00002, 5'b00001);
        idle(4);
        check("s1_note_on_t0", note_on_out, 5'b00001);
        check("s1_busy", busy_out, 1'b1);
        tick(2, 6'd1, NT_3C, 20'h00002, 5'b00001);
        idle(4);
        check("s1_note_on_t1", note_on_out, 5'b00001);
        tick(3, 6'd0, '0, '0, '0);
        check("s1_busy_end", busy_out, 1'b0);
        check("s1_note_on_end", note_on_out, 5'b00000);
        idle(4);
        do_reset("reset1");

        // 2: sustain across cells. Also covers rhythm 0 (16) and a late load.
        score[0] = {EMPTY, EMPTY, {4'd1, 8'h41}, {4'd0, 8'h40}, {4'd4, 8'h3C}};
        score[1] = {5{EMPTY}};
        score[2] = {EMPTY, {4'd3, 8'h50}, EMPTY, EMPTY, EMPTY};
        go(6'd5, 2, 6'd0, NT_S0, 20'h00104, 5'b00111);
        idle(4);
        tick(2, 6'd1, NT_S0, 20'h00104, 5'b00011);
        idle(4);
        tick(2, 6'd2, NT_S2, 20'h03104, 5'b01011);
        idle(4);
        check("s2_note0_held", notes_out[7:0], 8'h3C);
        tick(2, 6'd3, NT_S2, 20'h03104, 5'b01011);
        idle(4);
        check("s2_note_on0_t3", note_on_out[0], 1'b1);
        tick(2, 6'd4, NT_S2, 20'h03104, 5'b01010);
        idle(4);
        check("s2_note_on0_t4", note_on_out[0], 1'b0);
        check("s2_note0_after", notes_out[7:0], 8'h3C);
        tick(3, 6'd0, '0, '0, '0);
        check("s2_note_on_end", note_on_out, 5'b00000);
        idle(4);
        do_reset("reset2");

        // 3: loop with three cells. The third tick wraps to cell 0 with no done.
        score[0] = {EMPTY, EMPTY, EMPTY, EMPTY, {4'd8, 8'h60}};
        score[2] = {5{EMPTY}};
        loop_in = 1'b1;
        go(6'd3, 2, 6'd0, 40'hFFFF_FFFF_60, 20'h00008, 5'b00001);
        idle(4);
        tick(2, 6'd1, 40'hFFFF_FFFF_60, 20'h00008, 5'b00001);
        idle(4);
        tick(2, 6'd2, 40'hFFFF_FFFF_60, 20'h00008, 5'b00001);
        idle(4);
        tick(2, 6'd0, 40'hFFFF_FFFF_60, 20'h00008, 5'b00001);
        check("s3_wrap_addr", mem_addr_out, 6'd0);
        check("s3_wrap_busy", busy_out, 1'b1);
        idle(4);
        stop_pulse();
        loop_in = 1'b0;
        check("s3_stopped", busy_out, 1'b0);
        idle(4);
        do_reset("reset3");

        // 4: two ticks during FETCH/WAIT1. One advance happens and overrun sticks.
        score[0] = {EMPTY, EMPTY, EMPTY, EMPTY, {4'd5, 8'h70}};
        @(negedge clk_in);
        num_cells_in = 6'd3;
        start_in = 1'b1;
        push_ev(0, 6'd0, '0, '0, '0, cyc + 1);
        push_ev(1, 6'd0, 40'hFFFF_FFFF_70, 20'h00005, 5'b00001, cyc + 4);
        push_ev(0, 6'd1, '0, '0, '0, cyc + 5);
        push_ev(1, 6'd1, 40'hFFFF_FFFF_70, 20'h00005, 5'b00001, cyc + 8);
        @(negedge clk_in);
        start_in = 1'b0;
        sixteenth_tick_in = 1'b1;
        idle(2);
        sixteenth_tick_in = 1'b0;
        idle(10);
        check("s4_one_advance", current_staff_cell_out, 6'd1);
        check("s4_overrun", overrun_out, 1'b1);
        stop_pulse();
        idle(2);
        check("s4_overrun_sticky", overrun_out, 1'b1);
        do_reset("reset4");

        // 5: stop during WAIT1 of cell 1 clears the voices with no done.
        //    A simultaneous start+stop in IDLE does nothing.
        score[0] = {EMPTY, EMPTY, EMPTY, EMPTY, {4'd9, 8'h22}};
        go(6'd2, 2, 6'd0, 40'hFFFF_FFFF_22, 20'h00009, 5'b00001);
        idle(4);
        tick(1, 6'd1, '0, '0, '0);
        @(negedge clk_in);
        stop_in = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0;
        check("s5_busy", busy_out, 1'b0);
        check("s5_note_on", note_on_out, 5'b00000);
        idle(6);
        @(negedge clk_in);
        num_cells_in = 6'd3;
        start_in = 1'b1;
        stop_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        stop_in = 1'b0;
        idle(4);
        check("s5_startstop_busy", busy_out, 1'b0);
        do_reset("reset5");

        // 6: reset in the middle of PLAY, then in the middle of a fetch,
        //    then a start with zero cells.
        score[0] = {EMPTY, EMPTY, EMPTY, EMPTY, {4'd6, 8'h33}};
        go(6'd2, 2, 6'd0, 40'hFFFF_FFFF_33, 20'h00006, 5'b00001);
        idle(4);
        tick(2, 6'd1, 40'hFFFF_FFFF_33, 20'h00006, 5'b00001);
        idle(4);
        do_reset("rst_mid_play");
        go(6'd1, 1, 6'd0, '0, '0, '0);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1 check_reset_values("rst_mid_fetch");
        @(negedge clk_in);
        rst_in = 1'b0;
        idle(6);
        check("s6_fetch_discarded", notes_out, 40'hFFFF_FFFF_FF);
        check("s6_fetch_note_on", note_on_out, 5'b00000);
        go(6'd0, 3, 6'd0, '0, '0, '0);
        idle(4);
        check("s6_empty_busy", busy_out, 1'b0);

        idle(4);
        check("final_sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
